// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// The default BASE must track the CPU reset PC.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DAT_HI = 3'd2,
    ST_DAT_LO = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int unsigned DEFAULT_N    = 16;
  localparam int unsigned DEFAULT_M    = 1024;
  localparam int unsigned DEFAULT_BASE = 1;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader is the master of the memory write side.
interface program_loader_if
  import program_loader_pkg::*;
  #(parameter int N = DEFAULT_N);

  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_we;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Byte-pair register: holds the high byte, then presents {hi,lo} with
// a registered one-cycle write strobe.
module word_assembler #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hi_load,
  input  logic         wr_load,
  input  logic [7:0]   byte_in,
  input  logic [N-1:0] addr_in,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we
);

  logic [7:0]   hi_q, hi_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         we_q, we_d;

  always_comb begin
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    if (hi_load) begin
      hi_d = byte_in;
    end
    if (wr_load) begin
      addr_d  = addr_in;
      wdata_d = N'({hi_q, byte_in});
      we_d    = 1'b1;
    end
  end

  // The async clear of we_q is what guarantees no partial word on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian word stream into instruction memory
// starting at BASE, then raises done (or err for an oversize length).
module program_loader
  import program_loader_pkg::*;
  #(
  parameter int N    = DEFAULT_N,
  parameter int M    = DEFAULT_M,
  parameter int BASE = DEFAULT_BASE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  program_loader_if.master     bus,
  output logic                 done,
  output logic                 err
);

  localparam logic [15:0] MAX_LEN = 16'(M - BASE);

  state_t       state_q, state_d;
  logic [15:0]  len_q, len_d;
  logic [N-1:0] index_q, index_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         in_ready;
  logic         accept;
  logic         hi_load;
  logic         wr_load;
  logic [15:0]  len_full;
  logic [N-1:0] wr_addr;

  assign in_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                    (state_q == ST_DAT_HI) || (state_q == ST_DAT_LO);
  assign accept   = bus.in_valid && in_ready;
  assign len_full = {len_q[15:8], bus.in_data};
  assign wr_addr  = N'(BASE) + index_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    index_d = index_q;
    hi_load = 1'b0;
    wr_load = 1'b0;
    case (state_q)
      ST_LEN_HI: if (accept) begin
        len_d   = {bus.in_data, 8'h00};
        state_d = ST_LEN_LO;
      end
      ST_LEN_LO: if (accept) begin
        len_d = len_full;
        if (len_full == 16'd0) begin
          state_d = ST_DONE;
        end else if (len_full > MAX_LEN) begin
          state_d = ST_ERR;
        end else begin
          index_d = '0;
          state_d = ST_DAT_HI;
        end
      end
      ST_DAT_HI: if (accept) begin
        hi_load = 1'b1;
        state_d = ST_DAT_LO;
      end
      ST_DAT_LO: if (accept) begin
        wr_load = 1'b1;
        index_d = index_q + 1'b1;
        // len_q is at least 1 here, so len_q-1 cannot wrap.
        if (index_q == N'(len_q - 16'd1)) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_DAT_HI;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  if (restart) state_d = ST_LEN_HI;
      ST_ERR:   if (restart) state_d = ST_LEN_HI;
      default:  state_d = ST_LEN_HI;
    endcase
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LEN_HI;
      len_q   <= '0;
      index_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      index_q <= index_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  word_assembler #(.N(N)) u_word_assembler (
    .clk       (clk),
    .rst_n     (rst_n),
    .hi_load   (hi_load),
    .wr_load   (wr_load),
    .byte_in   (bus.in_data),
    .addr_in   (wr_addr),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .mem_we    (bus.mem_we)
  );

  assign bus.in_ready = in_ready;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; inputs driven and
// outputs sampled on the falling edge.
module tb_program_loader;
  import program_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic restart;
  logic done;
  logic err;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];

  program_loader_if #(.N(16)) bus();

  program_loader #(.N(16), .M(1024), .BASE(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .bus     (bus),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: sim time expired, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit sent;
    sent = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int n = 0; n < 20 && !sent; n++) begin
      if (bus.in_ready) sent = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    compared++;
    if (!sent) begin
      mismatched++;
      $display("[TB] FAIL send_accept: byte %h in_ready=0 for 20 cycles, required 1", b);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    restart      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    compared++;
    if (bus.in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    compared++;
    if (bus.mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_we: got %b required 0", bus.mem_we); end
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b required 0", done); end
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b required 0", err); end
    compared++;
    if (bus.mem_addr !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_mem_addr: got %h required 0000", bus.mem_addr); end
    compared++;
    if (bus.mem_wdata !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_mem_wdata: got %h required 0000", bus.mem_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_words();
    clear_log();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hA1); send_byte(8'h23);
    send_byte(8'h45); send_byte(8'h67);
    compared++;
    if (bus.mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL two_flush_we: got %b required 1", bus.mem_we); end
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL two_flush_done: got %b required 0", done); end
    @(negedge clk);
    compared++;
    if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL two_done: got %b required 1", done); end
    compared++;
    if (bus.in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL two_in_ready: got %b required 0", bus.in_ready); end
    compared++;
    if (wr_addr.size() != 2) begin
      mismatched++; $display("[TB] FAIL two_count: got %0d writes required 2", wr_addr.size());
    end else begin
      compared++;
      if (wr_addr[0] !== 16'd1 || wr_data[0] !== 16'hA123) begin
        mismatched++; $display("[TB] FAIL two_word0: got %h/%h required 0001/a123", wr_addr[0], wr_data[0]);
      end
      compared++;
      if (wr_addr[1] !== 16'd2 || wr_data[1] !== 16'h4567) begin
        mismatched++; $display("[TB] FAIL two_word1: got %h/%h required 0002/4567", wr_addr[1], wr_data[1]);
      end
    end
  endtask

  task automatic test_zero_len();
    pulse_restart();
    compared++;
    if (done !== 1'b0 || bus.in_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL zero_rearm: done=%b in_ready=%b required 0/1", done, bus.in_ready);
    end
    clear_log();
    send_byte(8'h00); send_byte(8'h00);
    compared++;
    if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_done: got %b required 1", done); end
    idle(3);
    compared++;
    if (wr_addr.size() != 0) begin mismatched++; $display("[TB] FAIL zero_writes: got %0d required 0", wr_addr.size()); end
  endtask

  task automatic test_len_error();
    pulse_restart();
    clear_log();
    send_byte(8'h04); send_byte(8'h00);
    compared++;
    if (err !== 1'b1 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
      mismatched++; $display("[TB] FAIL err_state: err=%b in_ready=%b done=%b required 1/0/0", err, bus.in_ready, done);
    end
    idle(3);
    compared++;
    if (wr_addr.size() != 0) begin mismatched++; $display("[TB] FAIL err_writes: got %0d required 0", wr_addr.size()); end
    pulse_restart();
    compared++;
    if (err !== 1'b0 || bus.in_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL err_restart: err=%b in_ready=%b required 0/1", err, bus.in_ready);
    end
    send_byte(8'h00); send_byte(8'h00);
    compared++;
    if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL err_relen: done=%b required 1", done); end
  endtask

  task automatic test_restart_with_valid();
    restart      = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    @(negedge clk);
    restart      = 1'b0;
    bus.in_valid = 1'b0;
    compared++;
    if (done !== 1'b0 || bus.in_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL rv_rearm: done=%b in_ready=%b required 0/1", done, bus.in_ready);
    end
    clear_log();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAB); send_byte(8'hCD);
    idle(2);
    compared++;
    if (wr_addr.size() != 1 || done !== 1'b1) begin
      mismatched++; $display("[TB] FAIL rv_count: writes=%0d done=%b required 1/1", wr_addr.size(), done);
    end else begin
      compared++;
      if (wr_addr[0] !== 16'd1 || wr_data[0] !== 16'hABCD) begin
        mismatched++; $display("[TB] FAIL rv_word: got %h/%h required 0001/abcd", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] stream [4];
    stream = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    pulse_restart();
    clear_log();
    for (int i = 0; i < 4; i++) begin
      idle(2);
      send_byte(stream[i]);
    end
    compared++;
    if (bus.mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL gap_we: got %b required 1", bus.mem_we); end
    @(negedge clk);
    compared++;
    if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL gap_done: got %b required 1", done); end
    compared++;
    if (wr_addr.size() != 1) begin
      mismatched++; $display("[TB] FAIL gap_count: got %0d required 1", wr_addr.size());
    end else begin
      compared++;
      if (wr_addr[0] !== 16'd1 || wr_data[0] !== 16'hBEEF) begin
        mismatched++; $display("[TB] FAIL gap_word: got %h/%h required 0001/beef", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    pulse_restart();
    clear_log();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    rst_n = 1'b0;
    #1;
    compared++;
    if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL mid_reset: mem_we=%b in_ready=%b required 0/1", bus.mem_we, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (done !== 1'b0 || wr_addr.size() != 0) begin
      mismatched++; $display("[TB] FAIL mid_nowrite: done=%b writes=%0d required 0/0", done, wr_addr.size());
    end
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'hFF);
    idle(2);
    compared++;
    if (wr_addr.size() != 1) begin
      mismatched++; $display("[TB] FAIL mid_count: got %0d required 1", wr_addr.size());
    end else begin
      compared++;
      if (wr_addr[0] !== 16'd1 || wr_data[0] !== 16'h00FF) begin
        mismatched++; $display("[TB] FAIL mid_word: got %h/%h required 0001/00ff", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  task automatic test_max_len();
    int bad;
    logic [15:0] w;
    pulse_restart();
    clear_log();
    send_byte(8'h03); send_byte(8'hFF);
    for (int i = 0; i < 1023; i++) begin
      w = 16'(i);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    @(negedge clk);
    compared++;
    if (done !== 1'b1 || err !== 1'b0) begin
      mismatched++; $display("[TB] FAIL max_flags: done=%b err=%b required 1/0", done, err);
    end
    compared++;
    if (wr_addr.size() != 1023) begin
      mismatched++; $display("[TB] FAIL max_count: got %0d required 1023", wr_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 1023; i++) begin
        if (wr_addr[i] !== 16'(i + 1) || wr_data[i] !== 16'(i)) bad++;
      end
      compared++;
      if (bad != 0) begin mismatched++; $display("[TB] FAIL max_contents: got %0d bad words required 0", bad); end
      compared++;
      if (wr_addr[1022] !== 16'd1023 || wr_data[1022] !== 16'h03FE) begin
        mismatched++; $display("[TB] FAIL max_last: got %h/%h required 03ff/03fe", wr_addr[1022], wr_data[1022]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_len_error();
    test_restart_with_valid();
    test_gaps();
    test_reset_mid();
    test_max_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
